// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the RV32M divide sequencer: funct3 codes, FSM states
// and a conditional two's-complement negate helper.
package div_ctrl_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [2:0] INST_DIV      = 3'b100;
  localparam logic [2:0] INST_DIVU     = 3'b101;
  localparam logic [2:0] INST_REM      = 3'b110;
  localparam logic [2:0] INST_REMU     = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic c);
    return c ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the BUSY phase.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o
);

  div_state_e state, state_nxt;

  logic [XLEN-1:0]  dvd, dsr, quo, rem, dividend_r;
  logic [CNT_W-1:0] count;
  logic [1:0]       op_r;
  logic [4:0]       rd_r;
  logic             dvd_neg, dsr_neg, dsr_zero, ovf;

  logic start_ok, in_signed, in_dvd_neg, in_dsr_neg, in_zero, in_ovf;
  logic [XLEN:0]    rem_sh, diff;
  logic             take;
  logic [XLEN-1:0]  res;

  assign start_ok   = start_i && op_i[2] && !flush_i;
  assign in_signed  = !op_i[0];
  assign in_dvd_neg = in_signed && dividend_i[XLEN-1];
  assign in_dsr_neg = in_signed && divisor_i[XLEN-1];
  assign in_zero    = (divisor_i == '0);
  assign in_ovf     = in_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (divisor_i == '1);

  // Partial remainder is kept one bit wider so divisors above 2^31 compare correctly.
  assign rem_sh = {rem, dvd[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dsr};
  assign take   = !diff[XLEN];

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hold_flag_o = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start_ok) begin
          hold_flag_o = 1'b1;
`ifdef DIV_EARLY_OUT_EN
          state_nxt = (in_zero || in_ovf) ? DIV_DONE : DIV_BUSY;
`else
          state_nxt = DIV_BUSY;
`endif
        end
      end
      DIV_BUSY: begin
        hold_flag_o = 1'b1;
        if (flush_i)          state_nxt = DIV_IDLE;
        else if (count == '1) state_nxt = DIV_DONE;
      end
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd        <= '0;
      dsr        <= '0;
      quo        <= '0;
      rem        <= '0;
      dividend_r <= '0;
      count      <= '0;
      op_r       <= '0;
      rd_r       <= '0;
      dvd_neg    <= 1'b0;
      dsr_neg    <= 1'b0;
      dsr_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_ok) begin
            op_r       <= op_i[1:0];
            rd_r       <= rd_addr_i;
            dvd_neg    <= in_dvd_neg;
            dsr_neg    <= in_dsr_neg;
            dsr_zero   <= in_zero;
            ovf        <= in_ovf;
            dividend_r <= dividend_i;
            dvd        <= neg_if(dividend_i, in_dvd_neg);
            dsr        <= neg_if(divisor_i, in_dsr_neg);
            quo        <= '0;
            rem        <= '0;
            count      <= '0;
          end
        end
        DIV_BUSY: begin
          if (!flush_i) begin
            dvd   <= {dvd[XLEN-2:0], 1'b0};
            rem   <= take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            quo   <= {quo[XLEN-2:0], take};
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (dsr_zero)     res = op_r[1] ? dividend_r : '1;
    else if (ovf)     res = op_r[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else if (op_r[1]) res = neg_if(rem, dvd_neg);
    else              res = neg_if(quo, dvd_neg ^ dsr_neg);
  end

  assign busy_o    = (state != DIV_IDLE);
  assign ready_o   = (state == DIV_DONE);
  assign rd_wen_o  = ready_o;
  assign result_o  = ready_o ? res : '0;
  assign rd_addr_o = ready_o ? rd_r : '0;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: cycle-level reference model plus directed vectors.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i, divisor_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o, hold_flag_o, ready_o, rd_wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY  = 1'b1;
  localparam int LAT_SP = 1;
`else
  localparam bit EARLY  = 1'b0;
  localparam int LAT_SP = 33;
`endif

  div_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .hold_flag_o(hold_flag_o),
    .ready_o(ready_o), .result_o(result_o), .rd_addr_o(rd_addr_o),
    .rd_wen_o(rd_wen_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension results from plain integer arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      3'b100:  return 32'(sa / sb);
      3'b101:  return a / b;
      3'b110:  return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Model: an accepted request is in flight until its ready cycle, cancelled by flush or reset.
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_ready_cyc = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk) begin
    if (rst) m_act = 1'b0;
    else if (m_act) begin
      if (cyc == m_ready_cyc) m_act = 1'b0;
      else if (flush_i)       m_act = 1'b0;
    end else if (start_i && op_i[2] && !flush_i) begin
      m_act       = 1'b1;
      m_ready_cyc = cyc + ((EARLY && is_special(op_i, dividend_i, divisor_i)) ? 1 : 33);
      m_res       = model_result(op_i, dividend_i, divisor_i);
      m_rd        = rd_addr_i;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic e_ready, e_hold;
    if (cyc >= 1) begin
      e_ready = m_act && (cyc == m_ready_cyc);
      e_hold  = m_act ? !e_ready : (start_i && op_i[2] && !flush_i);
      check("busy_o",      {31'd0, busy_o},      {31'd0, m_act});
      check("ready_o",     {31'd0, ready_o},     {31'd0, e_ready});
      check("rd_wen_o",    {31'd0, rd_wen_o},    {31'd0, e_ready});
      check("hold_flag_o", {31'd0, hold_flag_o}, {31'd0, e_hold});
      check("result_o",    result_o,             e_ready ? m_res : 32'd0);
      check("rd_addr_o",   {27'd0, rd_addr_o},   e_ready ? {27'd0, m_rd} : 32'd0);
    end
  end

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (!ready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int n;
    launch(op, a, b, rd);
    wait_ready(n);
    check({name, "_lat"}, n, exp_lat);
    check(name, result_o, exp);
    check({name, "_rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
  endtask

  task automatic expect_no_ready(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= ready_o;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {31'd0, busy_o},  32'd0);
    check("reset_ready",  {31'd0, ready_o}, 32'd0);
    check("reset_result", result_o,         32'd0);
    rst = 1'b0;

    run_op("divu_100_7",   3'b101, 32'd100,        32'd7,          5'd3,  32'd14,         33);
    run_op("div_m100_7",   3'b100, 32'hFFFF_FF9C,  32'd7,          5'd4,  32'hFFFF_FFF2,  33);
    run_op("rem_m100_7",   3'b110, 32'hFFFF_FF9C,  32'd7,          5'd5,  32'hFFFF_FFFE,  33);
    run_op("remu_100_7",   3'b111, 32'd100,        32'd7,          5'd0,  32'd2,          33);
    run_op("div_100_m7",   3'b100, 32'd100,        32'hFFFF_FFF9,  5'd6,  32'hFFFF_FFF2,  33);
    run_op("rem_100_m7",   3'b110, 32'd100,        32'hFFFF_FFF9,  5'd7,  32'd2,          33);
    run_op("divu_bigdsr",  3'b101, 32'hFFFF_FFFF,  32'h8000_0001,  5'd8,  32'd1,          33);
    run_op("remu_bigdsr",  3'b111, 32'hFFFF_FFFF,  32'h8000_0001,  5'd9,  32'h7FFF_FFFE,  33);
    run_op("div_5_0",      3'b100, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  LAT_SP);
    run_op("rem_5_0",      3'b110, 32'd5,          32'd0,          5'd11, 32'd5,          LAT_SP);
    run_op("remu_7_0",     3'b111, 32'd7,          32'd0,          5'd12, 32'd7,          LAT_SP);
    run_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  LAT_SP);
    run_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          LAT_SP);

    // Non-divide funct3 and start-with-flush are both ignored.
    launch(3'b001, 32'd9, 32'd3, 5'd1);
    check("non_div_ignored", {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; dividend_i = 32'd9; divisor_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_beats_start", {31'd0, busy_o}, 32'd0);

    // Flush at BUSY cycle 10.
    launch(3'b101, 32'd50, 32'd5, 5'd2);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_idle", {31'd0, busy_o}, 32'd0);
    expect_no_ready("flush_no_ready");
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd15, 32'd3, 33);

    // Start pulsed while BUSY does not disturb the op in flight.
    launch(3'b101, 32'd1000, 32'd10, 5'd16);
    repeat (4) begin @(posedge clk); #1; end
    start_i = 1'b1; op_i = 3'b100; dividend_i = 32'd7; divisor_i = 32'd1; rd_addr_i = 5'd17;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_ready(n);
    check("busy_start_result", result_o, 32'd100);
    check("busy_start_rd", {27'd0, rd_addr_o}, 32'd16);

    // Reset at BUSY cycle 20.
    launch(3'b101, 32'd100, 32'd7, 5'd18);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy",   {31'd0, busy_o},      32'd0);
    check("rst_mid_hold",   {31'd0, hold_flag_o}, 32'd0);
    check("rst_mid_ready",  {31'd0, ready_o},     32'd0);
    check("rst_mid_result", result_o,             32'd0);
    expect_no_ready("rst_no_ready");

    // Back-to-back: each run_op starts the cycle after the previous DONE.
    run_op("b2b_1", 3'b101, 32'd81,  32'd9, 5'd19, 32'd9,  33);
    run_op("b2b_2", 3'b111, 32'd83,  32'd9, 5'd20, 32'd2,  33);
    run_op("b2b_3", 3'b100, 32'd5,   32'd0, 5'd21, 32'hFFFF_FFFF, LAT_SP);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
